main_mem_responder: RTL and testbench

MAIN_MEM_RESPONDER -- requirements
Module: main_mem_responder

---
 rtl/main_mem_responder.sv | 127 ++++++++++++
 tb/tb_main_mem_responder.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/main_mem_responder.sv
// Byte-wide main memory model: single-byte writes and aligned 4-beat block reads over a shared data bus.
// First beat or write completion comes WAIT_CYCLES clocks after accept; requests made while ready_mem=0 are ignored.
module main_mem_responder #(
    parameter int ADDR_BITS   = 10,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] addr_mem,
    input  logic        rd_mem,
    input  logic        wr_mem,
    inout  wire  [7:0]  data_mem,
    output logic        ready_mem
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RWAIT = 2'd1;
    localparam logic [1:0] XFER  = 2'd2;
    localparam logic [1:0] WWAIT = 2'd3;

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES - 1);

    logic [1:0]           state_q, state_d;
    logic [3:0]           wait_q, wait_d;
    logic [1:0]           beat_q, beat_d;
    logic [ADDR_BITS-3:0] blk_q, blk_d;
    logic                 ready_q, ready_d;
    logic                 oe_q, oe_d;
    logic [7:0]           dout_q, dout_d;
    logic                 mem_we;

    logic [7:0] mem [2**ADDR_BITS];

    // Address bits above the storage index alias onto the same bytes.
    wire unused_addr_hi = ^addr_mem[15:ADDR_BITS];

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        beat_d  = beat_q;
        blk_d   = blk_q;
        ready_d = ready_q;
        oe_d    = oe_q;
        dout_d  = dout_q;
        mem_we  = 1'b0;
        case (state_q)
            IDLE: begin
                if (wr_mem) begin
                    mem_we  = 1'b1;
                    wait_d  = WAIT_INIT;
                    ready_d = 1'b0;
                    state_d = WWAIT;
                end else if (rd_mem) begin
                    blk_d   = addr_mem[ADDR_BITS-1:2];
                    wait_d  = WAIT_INIT;
                    ready_d = 1'b0;
                    state_d = RWAIT;
                end
            end
            RWAIT: begin
                if (wait_q == 4'd0) begin
                    beat_d  = 2'd0;
                    oe_d    = 1'b1;
                    dout_d  = mem[{blk_q, 2'b00}];
                    state_d = XFER;
                end else begin
                    wait_d = wait_q - 4'd1;
                end
            end
            XFER: begin
                // Beat index stays inside the block, so the burst never wraps past it.
                if (beat_q == 2'd3) begin
                    oe_d    = 1'b0;
                    ready_d = 1'b1;
                    state_d = IDLE;
                end else begin
                    beat_d = beat_q + 2'd1;
                    dout_d = mem[{blk_q, beat_q + 2'd1}];
                end
            end
            WWAIT: begin
                if (wait_q == 4'd0) begin
                    ready_d = 1'b1;
                    state_d = IDLE;
                end else begin
                    wait_d = wait_q - 4'd1;
                end
            end
            default: begin
                oe_d    = 1'b0;
                ready_d = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            wait_q  <= 4'd0;
            beat_q  <= 2'd0;
            blk_q   <= '0;
            ready_q <= 1'b1;
            oe_q    <= 1'b0;
            dout_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            beat_q  <= beat_d;
            blk_q   <= blk_d;
            ready_q <= ready_d;
            oe_q    <= oe_d;
            dout_q  <= dout_d;
        end
    end

    // Storage is never cleared; a write coinciding with reset is dropped.
    always_ff @(posedge clock) begin
        if (mem_we && !reset) begin
            mem[addr_mem[ADDR_BITS-1:0]] <= data_mem;
        end
    end

    assign ready_mem = ready_q;
    assign data_mem  = oe_q ? dout_q : 8'bzzzz_zzzz;

endmodule

// File: tb/tb_main_mem_responder.sv
// Directed bench: a WAIT_CYCLES=1 instance driven from a vector table, and a WAIT_CYCLES=3 instance by hand.
module tb_main_mem_responder;

    localparam logic [1:0] MZ = 2'd0;  // bus must be released
    localparam logic [1:0] MD = 2'd1;  // bus must carry dat
    localparam logic [1:0] MX = 2'd2;  // driven, content not defined

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        rst1 = 1'b1, rd1 = 1'b0, wr1 = 1'b0, toe1 = 1'b0;
    logic [15:0] addr1 = 16'h0;
    logic [7:0]  tdat1 = 8'h0;
    wire  [7:0]  data1;
    logic        rdy1;
    assign data1 = toe1 ? tdat1 : 8'bzzzz_zzzz;

    logic        rst3 = 1'b1, rd3 = 1'b0, wr3 = 1'b0, toe3 = 1'b0;
    logic [15:0] addr3 = 16'h0;
    logic [7:0]  tdat3 = 8'h0;
    wire  [7:0]  data3;
    logic        rdy3;
    assign data3 = toe3 ? tdat3 : 8'bzzzz_zzzz;

    main_mem_responder #(.ADDR_BITS(10), .WAIT_CYCLES(1)) u1 (
        .clock(clock), .reset(rst1), .addr_mem(addr1), .rd_mem(rd1),
        .wr_mem(wr1), .data_mem(data1), .ready_mem(rdy1)
    );

    main_mem_responder #(.ADDR_BITS(10), .WAIT_CYCLES(3)) u3 (
        .clock(clock), .reset(rst3), .addr_mem(addr3), .rd_mem(rd3),
        .wr_mem(wr3), .data_mem(data3), .ready_mem(rdy3)
    );

    typedef struct {
        logic        rst;
        logic        rd;
        logic        wr;
        logic [15:0] addr;
        logic [7:0]  wdat;
        logic        rdy;
        logic [1:0]  mode;
        logic [7:0]  dat;
    } vec_t;

    vec_t vq[$];
    int total = 0;
    int bad   = 0;

    task automatic add(input logic rst, input logic rd, input logic wr, input logic [15:0] addr,
                       input logic [7:0] wdat, input logic rdy, input logic [1:0] mode,
                       input logic [7:0] dat);
        vec_t v;
        v.rst = rst; v.rd = rd; v.wr = wr; v.addr = addr; v.wdat = wdat;
        v.rdy = rdy; v.mode = mode; v.dat = dat;
        vq.push_back(v);
    endtask

    task automatic idle(input logic rdy, input logic [1:0] mode, input logic [7:0] dat);
        add(1'b0, 1'b0, 1'b0, 16'h0, 8'h0, rdy, mode, dat);
    endtask

    task automatic chk(input string nm, input int idx, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s #%0d: got %h want %h", nm, idx, act, exp);
        end
    endtask

    // Any DUT drive on the bus disturbs the probe value placed on it by the bench.
    task automatic probe1(input int idx);
        toe1 = 1'b1; tdat1 = 8'h5A; #1;
        chk("w1 bus_released", idx, data1, 8'h5A);
        toe1 = 1'b0;
    endtask

    task automatic probe3(input int idx);
        toe3 = 1'b1; tdat3 = 8'h5A; #1;
        chk("w3 bus_released", idx, data3, 8'h5A);
        toe3 = 1'b0;
    endtask

    task automatic step3(input logic rst, input logic rd, input logic wr,
                         input logic [15:0] addr, input logic [7:0] wdat);
        rst3 = rst; rd3 = rd; wr3 = wr; addr3 = addr; tdat3 = wdat; toe3 = wr;
        @(posedge clock); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;

        // reset
        add(1'b1, 1'b0, 1'b0, 16'h0, 8'h0, 1'b1, MZ, 8'h0);
        add(1'b1, 1'b0, 1'b0, 16'h0, 8'h0, 1'b1, MZ, 8'h0);
        // fill 0x88..0x8B
        add(1'b0, 1'b0, 1'b1, 16'h0088, 8'h11, 1'b0, MZ, 8'h0); idle(1'b1, MZ, 8'h0);
        add(1'b0, 1'b0, 1'b1, 16'h0089, 8'h22, 1'b0, MZ, 8'h0); idle(1'b1, MZ, 8'h0);
        add(1'b0, 1'b0, 1'b1, 16'h008A, 8'h33, 1'b0, MZ, 8'h0); idle(1'b1, MZ, 8'h0);
        add(1'b0, 1'b0, 1'b1, 16'h008B, 8'h44, 1'b0, MZ, 8'h0); idle(1'b1, MZ, 8'h0);
        // unaligned, aliased read; requests during the tail of the burst are ignored
        add(1'b0, 1'b1, 1'b0, 16'hC08B, 8'h0, 1'b0, MZ, 8'h0);
        idle(1'b0, MD, 8'h11);
        idle(1'b0, MD, 8'h22);
        idle(1'b0, MD, 8'h33);
        add(1'b0, 1'b1, 1'b0, 16'h0090, 8'h0, 1'b0, MD, 8'h44);
        add(1'b0, 1'b1, 1'b0, 16'h0090, 8'h0, 1'b1, MZ, 8'h0);
        idle(1'b1, MZ, 8'h0);
        // single write then readback on beat 3
        add(1'b0, 1'b0, 1'b1, 16'h0093, 8'h23, 1'b0, MZ, 8'h0); idle(1'b1, MZ, 8'h0);
        add(1'b0, 1'b1, 1'b0, 16'h0090, 8'h0, 1'b0, MZ, 8'h0);
        idle(1'b0, MX, 8'h0); idle(1'b0, MX, 8'h0); idle(1'b0, MX, 8'h0);
        idle(1'b0, MD, 8'h23); idle(1'b1, MZ, 8'h0);
        // read and write together: write wins
        add(1'b0, 1'b1, 1'b1, 16'h00A0, 8'h77, 1'b0, MZ, 8'h0);
        idle(1'b1, MZ, 8'h0); idle(1'b1, MZ, 8'h0);
        add(1'b0, 1'b1, 1'b0, 16'h00A2, 8'h0, 1'b0, MZ, 8'h0);
        idle(1'b0, MD, 8'h77); idle(1'b0, MX, 8'h0); idle(1'b0, MX, 8'h0);
        idle(1'b0, MX, 8'h0); idle(1'b1, MZ, 8'h0);
        // reset during beat 1
        add(1'b0, 1'b1, 1'b0, 16'h0088, 8'h0, 1'b0, MZ, 8'h0);
        idle(1'b0, MD, 8'h11); idle(1'b0, MD, 8'h22);
        add(1'b1, 1'b0, 1'b0, 16'h0, 8'h0, 1'b1, MZ, 8'h0);
        idle(1'b1, MZ, 8'h0); idle(1'b1, MZ, 8'h0);
        // write coinciding with reset must not land
        add(1'b1, 1'b0, 1'b1, 16'h0089, 8'hEE, 1'b1, MZ, 8'h0);
        idle(1'b1, MZ, 8'h0);
        add(1'b0, 1'b1, 1'b0, 16'h008A, 8'h0, 1'b0, MZ, 8'h0);
        idle(1'b0, MD, 8'h11); idle(1'b0, MD, 8'h22); idle(1'b0, MD, 8'h33);
        idle(1'b0, MD, 8'h44); idle(1'b1, MZ, 8'h0);
        // aliasing: 0xFC00 and 0x0000 share a byte
        add(1'b0, 1'b0, 1'b1, 16'hFC00, 8'h5C, 1'b0, MZ, 8'h0); idle(1'b1, MZ, 8'h0);
        add(1'b0, 1'b1, 1'b0, 16'h0000, 8'h0, 1'b0, MZ, 8'h0);
        idle(1'b0, MD, 8'h5C); idle(1'b0, MX, 8'h0); idle(1'b0, MX, 8'h0);
        idle(1'b0, MX, 8'h0); idle(1'b1, MZ, 8'h0);

        foreach (vq[i]) begin
            rst1 = vq[i].rst; rd1 = vq[i].rd; wr1 = vq[i].wr;
            addr1 = vq[i].addr; tdat1 = vq[i].wdat; toe1 = vq[i].wr;
            @(posedge clock); #1;
            chk("w1 ready", i, {7'd0, rdy1}, {7'd0, vq[i].rdy});
            if (vq[i].mode == MD) chk("w1 beat", i, data1, vq[i].dat);
            else if (vq[i].mode == MZ) probe1(i);
        end
        rst1 = 1'b0; rd1 = 1'b0; wr1 = 1'b0; toe1 = 1'b0;

        // WAIT_CYCLES=3 instance
        step3(1'b1, 1'b0, 1'b0, 16'h0, 8'h0);
        chk("w3 reset ready", 0, {7'd0, rdy3}, 8'd1);
        probe3(0);
        for (int b = 0; b < 4; b++) begin
            n = 0;
            step3(1'b0, 1'b0, 1'b1, 16'(16'h0140 + b), 8'(8'hA0 + b));
            while (rdy3 === 1'b0 && n < 20) begin
                n++;
                step3(1'b0, 1'b0, 1'b0, 16'h0, 8'h0);
            end
            chk("w3 write busy cycles", b, 8'(n), 8'd3);
        end
        // read accepted, dropped one cycle, re-asserted through the burst
        for (int c = 0; c < 9; c++) begin
            step3(1'b0, (c == 0) || (c >= 2 && c <= 7), 1'b0,
                  (c == 0) ? 16'h0141 : 16'h0100, 8'h0);
            chk("w3 burst ready", c, {7'd0, rdy3}, (c >= 7) ? 8'd1 : 8'd0);
            if (c >= 3 && c <= 6) chk("w3 burst beat", c, data3, 8'(8'hA0 + c - 3));
            else probe3(c);
        end
        // reset during write wait aborts it at once
        step3(1'b0, 1'b0, 1'b1, 16'h0150, 8'h99);
        chk("w3 wwait busy", 0, {7'd0, rdy3}, 8'd0);
        step3(1'b1, 1'b0, 1'b0, 16'h0, 8'h0);
        chk("w3 wwait abort", 0, {7'd0, rdy3}, 8'd1);
        step3(1'b0, 1'b0, 1'b0, 16'h0, 8'h0);
        chk("w3 after abort", 0, {7'd0, rdy3}, 8'd1);
        probe3(99);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
